mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares the single 16-bit memory port between four requesters: instruction fetch, load/store, VGA reader, and I/O.
- Drives the 2-bit select of the 4-input address/write-data muxes in front of the memory, plus a one-hot grant vector and a gated write enable.
- Pure control block: no data passes through it.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles for one owner while another requester is waiting. Legal range is 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- req  input  4  request per requester; bit 0 = fetch, 1 = load/store, 2 = VGA, 3 = I/O.
- we_in  input  4  per-requester write intent; meaningful only while that requester is granted.
- gnt  output  4  one-hot grant, registered; 0 when no owner.
- sel  output  2  mux select = index of current owner, registered.
- mem_we  output  1  memory write enable = we_in[sel] while a grant is active, else 0 (combinational from registered state).
- busy  output  1  1 whenever gnt != 0.

Behaviour:
- Reset (reset = 0 at a rising edge): state = IDLE, gnt = 0, sel = 0, busy = 0, mem_we = 0, hold counter = 0, last-owner pointer = 3, so requester 0 wins first.
- Winner selection: scan req starting at (last + 1) mod 4, wrapping; the first set bit wins. The scan excludes the current owner when preempting.
- States:
  - IDLE: if req != 0, next state GRANT; gnt = onehot(winner), sel = winner, last = winner, counter = 0. Latency from req to gnt is 1 cycle. If req == 0, stay in IDLE; sel holds its old value.
  - GRANT, owner drops req with others pending: switch directly to the next winner on the following edge with no bubble. Counter resets to 0 and last updates.
  - GRANT, owner drops req with none pending: go to IDLE with gnt = 0.
  - GRANT, owner keeps req: counter increments, saturating at MAX_HOLD-1.
  - GRANT, preemption: when counter == MAX_HOLD-1 and any other req is set while the owner still requests, go to RELEASE.
  - GRANT, no contention: with no other requester waiting, the owner keeps the grant indefinitely. The counter stays saturated and preemption fires as soon as another request appears.
  - RELEASE: exactly one cycle with gnt = 0, busy = 0, mem_we = 0 and sel unchanged. Next state is GRANT to the winner computed from req, excluding the preempted owner. If no other req remains, re-grant the preempted owner if it still requests; otherwise go to IDLE.
- Requester contract:
  - A requester holds req high until it sees its gnt bit.
  - It may drop req at any time; the grant is removed on the next edge.
  - Requests seen in the same cycle resolve by round-robin order only.
- Simultaneous events:
  - If the owner drops req in the same cycle the counter saturates, the drop path wins (no RELEASE).
  - All four requesting continuously gives service order 0,1,2,3,0… with MAX_HOLD grant cycles each, separated by one RELEASE cycle.
- Reset mid-grant: the outputs clear on that edge; no RELEASE cycle is inserted.
- Invariants: gnt is always one-hot or zero, and mem_we is never 1 while gnt == 0.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index set bit of req, and the last pointer is ignored. Preemption still applies: the preempted owner is excluded and the lowest-index other requester wins.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: hold reset = 0 for 2 cycles with req = 4'b1111. Expect gnt = 0, sel = 0, busy = 0, mem_we = 0. Release reset; one cycle later expect gnt = 4'b0001 and sel = 0.
- Handoff: req = 4'b0010 for 3 cycles, then req = 4'b0100. Expect gnt = 0010 for 3 cycles, then gnt = 0100 on the next edge with no zero cycle between.
- Preemption (MAX_HOLD = 8): hold req = 4'b0011. Expect gnt = 0001 for 8 cycles, 1 cycle of gnt = 0, then gnt = 0010 for 8 cycles, 1 zero cycle, then 0001.
- Write gating: owner 1 granted with we_in = 4'b0010 gives mem_we = 1. we_in = 4'b0001 gives mem_we = 0. During RELEASE, mem_we = 0.
- Reset mid-operation: while gnt = 0100, drive reset = 0 for 1 cycle. Gnt clears on that edge. After reset with req = 4'b1100, expect gnt = 0100, since the last pointer reset to 3.
- Fixed-priority build (MEM_ARB_FIXED_PRIO_EN defined): req = 4'b1010 gives gnt = 0010 every grant window. Requester 3 gets only the windows in which it is the sole other requester when 1 is preempted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin owner arbiter for the shared 16-bit memory port (fetch, load/store, VGA, I/O).
// Build with MEM_ARB_FIXED_PRIO_EN defined to replace round-robin with lowest-index-wins priority.
module mem_port_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] we_in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       mem_we,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mem_port_arbiter: MAX_HOLD must lie in 2..255");
  end
  if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("mem_port_arbiter: CNT_W too narrow for MAX_HOLD");
  end

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             owner_req;
  logic [3:0]       others;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Lowest index wins; the last-owner pointer plays no part in this build.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] unused_last;
    unused_last = last;
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) pick = 2'(i);
    end
  endfunction
`else
  // Scan starts one past the previous owner and wraps, so the previous owner is checked last.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction
`endif

  assign owner_req = req[sel_q];
  assign others    = req & ~onehot(sel_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (req != 4'b0000) begin
          state_d = GRANT;
          sel_d   = pick(req, last_q);
          gnt_d   = onehot(sel_d);
          last_d  = sel_d;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // A drop always wins over a saturating counter, so no RELEASE here.
          cnt_d = '0;
          if (others != 4'b0000) begin
            sel_d  = pick(others, last_q);
            gnt_d  = onehot(sel_d);
            last_d = sel_d;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (cnt_q == HOLD_LAST && others != 4'b0000) begin
          state_d = RELEASE;
          gnt_d   = 4'b0000;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        // sel_q still names the preempted owner; it competes only if nobody else asks.
        cnt_d = '0;
        if (others != 4'b0000) begin
          state_d = GRANT;
          sel_d   = pick(others, last_q);
          gnt_d   = onehot(sel_d);
          last_d  = sel_d;
        end else if (owner_req) begin
          state_d = GRANT;
          gnt_d   = onehot(sel_q);
          last_d  = sel_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign busy   = (gnt_q != 4'b0000);
  assign mem_we = busy & we_in[sel_q];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each step queues the expected {gnt, sel, mem_we, busy}
// and checks it one edge later; MEM_ARB_FIXED_PRIO_EN selects the matching final scenario.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] we_in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       mem_we;
  logic       busy;

  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we_in  (we_in),
    .gnt    (gnt),
    .sel    (sel),
    .mem_we (mem_we),
    .busy   (busy)
  );

  function automatic logic [7:0] ex(input logic [3:0] g, input logic [1:0] s, input logic m);
    return {g, s, m, (g != 4'b0000)};
  endfunction

  // Drive one cycle, queue its expectation, then check after the edge.
  task automatic cyc(input logic rst_v, input logic [3:0] r, input logic [3:0] w,
                     input logic [7:0] e, input string tag);
    logic [7:0] obs;
    logic [7:0] want;
    logic       inv;
    reset = rst_v;
    req   = r;
    we_in = w;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs  = {gnt, sel, mem_we, busy};
    want = exp_q.pop_front();
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed gnt=%b sel=%0d we=%b busy=%b, expected gnt=%b sel=%0d we=%b busy=%b",
             tag, obs[7:4], obs[3:2], obs[1], obs[0], want[7:4], want[3:2], want[1], want[0]);
    end
    inv = $onehot0(gnt) && !(mem_we && gnt == 4'b0000);
    n_tests++;
    assert (inv === 1'b1) else begin
      n_fail++;
      $error("FAIL %s_invariant: observed gnt=%b mem_we=%b, expected one-hot/zero gnt and no write without grant",
             tag, gnt, mem_we);
    end
  endtask

  task automatic rep(input int n, input logic [3:0] r, input logic [3:0] w,
                     input logic [7:0] e, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b1, r, w, e, tag);
  endtask

  initial begin
    reset = 1'b0;
    req   = 4'b1111;
    we_in = 4'b0000;

    // Reset with everyone requesting, then first grant goes to requester 0.
    cyc(1'b0, 4'b1111, 4'b0000, ex(4'b0000, 2'd0, 1'b0), "reset_hold0");
    cyc(1'b0, 4'b1111, 4'b0000, ex(4'b0000, 2'd0, 1'b0), "reset_hold1");
    cyc(1'b1, 4'b1111, 4'b0000, ex(4'b0001, 2'd0, 1'b0), "first_grant");
    cyc(1'b0, 4'b0000, 4'b0000, ex(4'b0000, 2'd0, 1'b0), "reset_clear");

    // Handoff without a bubble.
    rep(3, 4'b0010, 4'b0000, ex(4'b0010, 2'd1, 1'b0), "handoff_own1");
    cyc(1'b1, 4'b0100, 4'b0000, ex(4'b0100, 2'd2, 1'b0), "handoff_to2");

    // Reset while 2 owns the port; pointer back at 3 so 2 beats 3.
    cyc(1'b0, 4'b1100, 4'b0000, ex(4'b0000, 2'd0, 1'b0), "mid_reset");
    cyc(1'b1, 4'b1100, 4'b0000, ex(4'b0100, 2'd2, 1'b0), "post_reset_grant");
    rep(2, 4'b0000, 4'b0000, ex(4'b0000, 2'd2, 1'b0), "idle_sel_hold");

    // Preemption between 0 and 1 with write gating in owner 1's window.
    cyc(1'b0, 4'b0000, 4'b0000, ex(4'b0000, 2'd0, 1'b0), "reset_again");
    rep(8, 4'b0011, 4'b0000, ex(4'b0001, 2'd0, 1'b0), "preempt_own0");
    cyc(1'b1, 4'b0011, 4'b0010, ex(4'b0000, 2'd0, 1'b0), "release0");
    rep(4, 4'b0011, 4'b0010, ex(4'b0010, 2'd1, 1'b1), "we_own1");
    rep(4, 4'b0011, 4'b0001, ex(4'b0010, 2'd1, 1'b0), "we_other");
    cyc(1'b1, 4'b0011, 4'b0010, ex(4'b0000, 2'd1, 1'b0), "release1_we");
    cyc(1'b1, 4'b0011, 4'b0000, ex(4'b0001, 2'd0, 1'b0), "back_to0");

    // Owner drops on the saturating cycle: direct switch, no RELEASE.
    rep(7, 4'b0011, 4'b0000, ex(4'b0001, 2'd0, 1'b0), "sat_own0");
    cyc(1'b1, 4'b0010, 4'b0000, ex(4'b0010, 2'd1, 1'b0), "drop_at_sat");
    cyc(1'b1, 4'b0000, 4'b0000, ex(4'b0000, 2'd1, 1'b0), "drop_to_idle");

    // Uncontended owner keeps the port; preemption is immediate once 0 asks.
    rep(12, 4'b0100, 4'b0000, ex(4'b0100, 2'd2, 1'b0), "no_contention");
    cyc(1'b1, 4'b0101, 4'b0000, ex(4'b0000, 2'd2, 1'b0), "late_preempt");
    cyc(1'b1, 4'b0101, 4'b0000, ex(4'b0001, 2'd0, 1'b0), "late_winner");
    cyc(1'b1, 4'b0000, 4'b0000, ex(4'b0000, 2'd0, 1'b0), "idle_again");

    // Contender vanishes during RELEASE: preempted owner is re-granted.
    rep(8, 4'b0010, 4'b0000, ex(4'b0010, 2'd1, 1'b0), "regrant_own1");
    cyc(1'b1, 4'b0011, 4'b0000, ex(4'b0000, 2'd1, 1'b0), "regrant_release");
    cyc(1'b1, 4'b0010, 4'b0000, ex(4'b0010, 2'd1, 1'b0), "regrant_back");
    cyc(1'b1, 4'b0000, 4'b0000, ex(4'b0000, 2'd1, 1'b0), "regrant_idle");

`ifdef MEM_ARB_FIXED_PRIO_EN
    // 1 always wins a fresh window; 3 only gets the slot after 1 is preempted.
    rep(8, 4'b1010, 4'b0000, ex(4'b0010, 2'd1, 1'b0), "fixed_own1");
    cyc(1'b1, 4'b1010, 4'b0000, ex(4'b0000, 2'd1, 1'b0), "fixed_rel1");
    rep(8, 4'b1010, 4'b0000, ex(4'b1000, 2'd3, 1'b0), "fixed_own3");
    cyc(1'b1, 4'b1010, 4'b0000, ex(4'b0000, 2'd3, 1'b0), "fixed_rel3");
    cyc(1'b1, 4'b1010, 4'b0000, ex(4'b0010, 2'd1, 1'b0), "fixed_back1");
`else
    // All four requesting, last owner 1: service order 2,3,0.
    rep(8, 4'b1111, 4'b0000, ex(4'b0100, 2'd2, 1'b0), "rr_own2");
    cyc(1'b1, 4'b1111, 4'b0000, ex(4'b0000, 2'd2, 1'b0), "rr_rel2");
    rep(8, 4'b1111, 4'b0000, ex(4'b1000, 2'd3, 1'b0), "rr_own3");
    cyc(1'b1, 4'b1111, 4'b0000, ex(4'b0000, 2'd3, 1'b0), "rr_rel3");
    cyc(1'b1, 4'b1111, 4'b0000, ex(4'b0001, 2'd0, 1'b0), "rr_own0");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
